icb_result_writer: RTL and testbench
====================================

Name: icb_result_writer

Overview:
- ICB master that moves systolic-array results out to system memory; it is the initiator counterpart of the accelerator's ICB slave port.
- Accepts 64-bit result beats (data, row address, active-low write strobe) from the SA output, buffers them in a small FIFO, and issues two 32-bit ICB write commands per beat at base_addr + 8*waddr.
- Reports completion after a flush request and tracks response errors and input overflow.

Parameters:
- DEPTH, 4, result FIFO depth in 64-bit beats (power of 2, >=2).
- MAX_OUT, 2, max outstanding ICB writes (commands accepted, response not yet received), 1..7.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: latch base_addr, clear err/ovf/done
- base_addr  in  32  destination byte base address (8-byte aligned)
- flush  in  1  one-cycle pulse: request done once all data is written
- wen_n  in  1  active-low result write strobe
- waddr  in  13  result beat index
- data_out  in  64  result data
- in_ready  out  1  FIFO not full
- busy  out  1  FIFO non-empty, command pending, or outstanding>0
- done  out  1  one-cycle completion pulse
- err  out  1  sticky: an ICB response returned with err=1
- ovf  out  1  sticky: beat presented while in_ready=0 (beat dropped)
- icb_cmd_valid  out  1  command valid
- icb_cmd_ready  in  1  command accepted
- icb_cmd_read  out  1  tied 0
- icb_cmd_addr  out  32  byte address
- icb_cmd_wdata  out  32  write data
- icb_cmd_wmask  out  4  constant 4'hF
- icb_rsp_valid  in  1  response valid
- icb_rsp_ready  out  1  constant 1
- icb_rsp_rdata  in  32  ignored
- icb_rsp_err  in  1  response error

Behaviour:
- Reset: FIFO empty, FSM=IDLE, outstanding=0, base register=0, flush_pend=0. Outputs: cmd_valid=0, addr=0, wdata=0, done=0, err=0, ovf=0, busy=0, in_ready=1.
- Push: a beat is pushed when wen_n=0 and in_ready=1. If wen_n=0 and in_ready=0, the beat is dropped and ovf is set.
- in_ready=!full uses the FIFO count at the start of the cycle. A same-cycle pop does not enable a push when the FIFO is full.
- FSM states:
  - IDLE: if FIFO non-empty and outstanding<MAX_OUT, load the command registers with addr=base+{waddr,3'b000} and wdata=data[31:0], set cmd_valid, go to LO.
  - LO: hold addr/wdata stable while valid && !ready. On handshake: if outstanding (after update) <MAX_OUT, present addr+4 and data[63:32] the next cycle and go to HI. Otherwise drop valid and go to HI_WAIT.
  - HI_WAIT: when outstanding<MAX_OUT, assert valid with the high word and go to HI.
  - HI: on handshake, pop the FIFO and return to IDLE. IDLE may issue the next beat's low word on the following cycle (one-cycle bubble allowed).
- Latency: a beat pushed into an empty FIFO in an idle block gives cmd_valid=1 for its low word 2 cycles after the push edge.
- Outstanding counter:
  - +1 on command handshake, -1 on response handshake; both in the same cycle leaves it unchanged.
  - A command is never asserted while outstanding==MAX_OUT.
- Address arithmetic is modulo 2^32 (wraps silently). waddr is zero-extended.
- Response: icb_rsp_ready is always 1. err is set on any rsp handshake with icb_rsp_err=1 and held until start or reset. Data is never retried.
- start:
  - Honoured only when busy=0 and cmd_valid=0; ignored otherwise, with no flag changes.
  - When honoured, base_addr is latched the same cycle; beats pushed in that cycle use the new base.
- flush:
  - Sets flush_pend.
  - When flush_pend=1, FIFO empty, FSM=IDLE and outstanding==0 (evaluated the cycle after the last response), done pulses for 1 cycle and flush_pend clears.
  - flush while already idle gives done the next cycle.
  - flush while flush_pend=1 has no extra effect.
- Reset asserted mid-transfer: immediate return to reset state. In-flight responses arriving afterwards are ignored (counter floors at 0, never underflows).

Test Plan:
- Single beat: start with base=0x2000_0000; push waddr=3, data=0x1111_2222_3333_4444; cmd_ready=1, rsp after 1 cycle -> writes (0x2000_0018, 0x3333_4444) then (0x2000_001C, 0x1111_2222), wmask=F, read=0; then flush -> done pulse once, busy=0.
- Backpressure: cmd_ready=0 for 5 cycles during LO -> addr/wdata held constant, valid stays 1. Release -> exactly 2 commands for the beat.
- Outstanding limit: MAX_OUT=2, responses withheld -> exactly 2 handshakes, then cmd_valid=0. Release one response -> next command issued.
- FIFO full: DEPTH=4, cmd_ready=0, push 5 consecutive beats -> in_ready=0 after 4, ovf=1, 4 beats (8 writes) emitted after release, 5th absent.
- Error: return rsp_err=1 on the 2nd response -> err=1 sticky, remaining writes still issued, done still pulses. A following start clears err.
- Wrap and reset: base=0xFFFF_FFF8, waddr=1 -> addr 0x0000_0000 then 0x0000_0004. Assert rst_n=0 during HI -> all outputs at reset values the same cycle.

Source files
------------

// File: rtl/icb_result_writer_if.sv
// ICB command/response bus between the result writer (initiator) and system memory.
// Master drives commands and response-ready; slave drives command-ready and responses.
interface icb_result_writer_if;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_addr;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;

    modport master (
        output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );
endinterface

// File: rtl/icb_result_writer.sv
// Buffers 64-bit systolic-array result beats and writes each out as two 32-bit ICB
// write commands at base + 8*waddr, with outstanding-write limiting and flush/done.
module icb_result_writer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        flush,
    input  logic        wen_n,
    input  logic [12:0] waddr,
    input  logic [63:0] data_out,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        ovf,
    icb_result_writer_if.master icb
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = 3;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUT);

    typedef struct packed {
        logic [12:0] waddr;
        logic [63:0] data;
    } beat_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI_WAIT,
        S_HI
    } state_t;

    beat_t           mem [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    beat_t           head;

    state_t          state_q;
    state_t          state_d;
    logic            cmd_valid_q;
    logic            cmd_valid_d;
    logic [31:0]     addr_q;
    logic [31:0]     addr_d;
    logic [31:0]     wdata_q;
    logic [31:0]     wdata_d;

    logic [OW-1:0]   out_q;
    logic [OW-1:0]   out_d;
    logic            cmd_hs;
    logic            rsp_live;

    logic [31:0]     base_q;
    logic            flush_pend_q;
    logic            start_ok;
    logic            done_fire;
    logic            err_q;
    logic            ovf_q;
    logic            done_q;
    logic            unused_rdata;

    // FIFO occupancy: in_ready reflects the count at the start of the cycle only
    assign fifo_empty = (count_q == '0);
    assign in_ready   = (count_q != FULL_CNT);
    assign push       = ~wen_n & in_ready;
    assign count_d    = count_q + CW'(push) - CW'(pop);
    assign head       = mem[rptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= '{waddr: waddr, data: data_out};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Outstanding writes; stray responses after reset must not underflow the counter
    assign cmd_hs   = cmd_valid_q & icb.icb_cmd_ready;
    assign rsp_live = icb.icb_rsp_valid & (out_q != '0);
    assign out_d    = out_q + OW'(cmd_hs) - OW'(rsp_live);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command sequencing: low word, then high word, pop only after the high word is taken
    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pop         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty && (out_q < OUT_MAX)) begin
                    addr_d      = base_q + {16'd0, head.waddr, 3'd0};
                    wdata_d     = head.data[31:0];
                    cmd_valid_d = 1'b1;
                    state_d     = S_LO;
                end
            end
            S_LO: begin
                if (cmd_hs) begin
                    if (out_d < OUT_MAX) begin
                        addr_d      = addr_q + 32'd4;
                        wdata_d     = head.data[63:32];
                        cmd_valid_d = 1'b1;
                        state_d     = S_HI;
                    end else begin
                        cmd_valid_d = 1'b0;
                        state_d     = S_HI_WAIT;
                    end
                end
            end
            S_HI_WAIT: begin
                if (out_q < OUT_MAX) begin
                    addr_d      = addr_q + 32'd4;
                    wdata_d     = head.data[63:32];
                    cmd_valid_d = 1'b1;
                    state_d     = S_HI;
                end
            end
            S_HI: begin
                if (cmd_hs) begin
                    pop         = 1'b1;
                    cmd_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                cmd_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign busy      = ~fifo_empty | cmd_valid_q | (state_q != S_IDLE) | (out_q != '0);
    assign start_ok  = start & ~busy & ~cmd_valid_q;
    assign done_fire = (flush | flush_pend_q) & fifo_empty & (state_q == S_IDLE)
                     & (out_q == '0) & ~start_ok;

    // Base register, sticky flags and the flush/done handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q       <= '0;
            flush_pend_q <= 1'b0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q       <= done_fire;
            flush_pend_q <= done_fire ? 1'b0 : (flush_pend_q | flush);
            if (start_ok) begin
                base_q <= base_addr;
                err_q  <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                if (rsp_live && icb.icb_rsp_err) begin
                    err_q <= 1'b1;
                end
                if (!wen_n && !in_ready) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign done = done_q;
    assign err  = err_q;
    assign ovf  = ovf_q;

    assign icb.icb_cmd_valid = cmd_valid_q;
    assign icb.icb_cmd_read  = 1'b0;
    assign icb.icb_cmd_addr  = addr_q;
    assign icb.icb_cmd_wdata = wdata_q;
    assign icb.icb_cmd_wmask = 4'hF;
    assign icb.icb_rsp_ready = 1'b1;

    // Read data is meaningless for write responses
    assign unused_rdata = ^icb.icb_rsp_rdata;

endmodule

// File: tb/tb_icb_result_writer.sv
// Scoreboard bench for icb_result_writer: stimulus queues expected ICB writes,
// a negedge monitor pops and compares on every command handshake.
module tb_icb_result_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        flush = 1'b0;
    logic        wen_n = 1'b1;
    logic [12:0] waddr = '0;
    logic [63:0] data_out = '0;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic        ovf;

    icb_result_writer_if bus ();

    icb_result_writer #(.DEPTH(4), .MAX_OUT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .flush     (flush),
        .wen_n     (wen_n),
        .waddr     (waddr),
        .data_out  (data_out),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ovf       (ovf),
        .icb       (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t        sb_q[$];
    cmd_t        mon_exp;
    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    int          out_m = 0;
    int          rsp_num = 0;
    int          rsp_used = 0;
    int          rsp_allow = 0;
    int          bias = 0;
    int          err_target = -1;
    bit          rsp_hold = 1'b0;
    logic        cmd_ready_m = 1'b0;
    logic        rsp_v = 1'b0;
    logic        rsp_e = 1'b0;
    logic [31:0] rsp_d = '0;
    logic [31:0] base_m = '0;

    assign bus.icb_cmd_ready = cmd_ready_m;
    assign bus.icb_rsp_valid = rsp_v;
    assign bus.icb_rsp_err   = rsp_e;
    assign bus.icb_rsp_rdata = rsp_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard compare on handshake, outstanding-limit check, done counting
    always @(negedge clk) begin
        if (!rst_n) begin
            out_m = 0;
        end else begin
            if (bus.icb_cmd_valid) begin
                checks++;
                if (out_m >= 2) begin
                    errors++;
                    $display("FAIL outstanding_limit: cmd_valid with %0d outstanding, limit 2", out_m);
                end
            end
            if (bus.icb_cmd_valid && bus.icb_cmd_ready) begin
                hs_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd: addr 0x%0h wdata 0x%0h, expected no command",
                             bus.icb_cmd_addr, bus.icb_cmd_wdata);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("cmd_addr", 64'(bus.icb_cmd_addr), 64'(mon_exp.addr));
                    check("cmd_wdata", 64'(bus.icb_cmd_wdata), 64'(mon_exp.wdata));
                    check("cmd_read", 64'(bus.icb_cmd_read), 64'(0));
                    check("cmd_wmask", 64'(bus.icb_cmd_wmask), 64'hF);
                end
                out_m++;
            end
            if (bus.icb_rsp_valid && out_m > 0) begin
                out_m--;
            end
            if (done) begin
                done_cnt++;
            end
        end
    end

    // Responder: one response per accepted command, optionally held back
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            rsp_v = 1'b0;
            rsp_e = 1'b0;
        end else if ((hs_cnt - rsp_num + bias) > 0 && (!rsp_hold || rsp_used < rsp_allow)) begin
            if (rsp_hold) begin
                rsp_used++;
            end
            rsp_num++;
            rsp_v = 1'b1;
            rsp_e = (rsp_num == err_target);
            rsp_d = $urandom;
        end else begin
            rsp_v = 1'b0;
            rsp_e = 1'b0;
        end
    end

    task automatic do_start(input logic [31:0] b);
        start     = 1'b1;
        base_addr = b;
        base_m    = b;
        tick();
        start     = 1'b0;
    endtask

    task automatic push_beat(input logic [12:0] wa, input logic [63:0] d, input bit expect_it);
        logic [31:0] a;
        a        = base_m + {16'd0, wa, 3'd0};
        wen_n    = 1'b0;
        waddr    = wa;
        data_out = d;
        if (expect_it) begin
            sb_q.push_back('{addr: a, wdata: d[31:0]});
            sb_q.push_back('{addr: a + 32'd4, wdata: d[63:32]});
        end
        tick();
        wen_n = 1'b1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || sb_q.size() != 0 || (hs_cnt - rsp_num + bias) != 0 || rsp_v) && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s: still busy after 400 cycles, busy=%0b pending_writes=%0d",
                     name, busy, sb_q.size());
        end
        repeat (2) tick();
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.icb_cmd_valid && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL %s: cmd_valid=0 after 50 cycles, expected 1", name);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_valid"}, 64'(bus.icb_cmd_valid), 64'(0));
        check({tag, "_cmd_addr"},  64'(bus.icb_cmd_addr),  64'(0));
        check({tag, "_cmd_wdata"}, 64'(bus.icb_cmd_wdata), 64'(0));
        check({tag, "_done"},      64'(done),              64'(0));
        check({tag, "_err"},       64'(err),               64'(0));
        check({tag, "_ovf"},       64'(ovf),               64'(0));
        check({tag, "_busy"},      64'(busy),              64'(0));
        check({tag, "_in_ready"},  64'(in_ready),          64'(1));
        check({tag, "_rsp_ready"}, 64'(bus.icb_rsp_ready), 64'(1));
    endtask

    initial begin
        int hs0;
        int d0;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Single beat, two-cycle latency, then flush from idle
        cmd_ready_m = 1'b1;
        do_start(32'h2000_0000);
        push_beat(13'd3, 64'h1111_2222_3333_4444, 1'b1);
        check("single_busy", 64'(busy), 64'(1));
        check("single_valid_early", 64'(bus.icb_cmd_valid), 64'(0));
        tick();
        check("single_valid_lat", 64'(bus.icb_cmd_valid), 64'(1));
        check("single_addr_lo", 64'(bus.icb_cmd_addr), 64'h2000_0018);
        wait_idle("single_idle");
        d0 = done_cnt;
        pulse_flush();
        repeat (4) tick();
        check("single_done_once", 64'(done_cnt - d0), 64'(1));
        check("single_done_low", 64'(done), 64'(0));
        check("single_busy_end", 64'(busy), 64'(0));

        // Backpressure in LO; a start while busy must be ignored
        cmd_ready_m = 1'b0;
        hs0 = hs_cnt;
        push_beat(13'd5, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
        wait_valid("bp_valid");
        start     = 1'b1;
        base_addr = 32'hDEAD_0000;
        tick();
        start     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_hold", 64'(bus.icb_cmd_valid), 64'(1));
            check("bp_addr_hold", 64'(bus.icb_cmd_addr), 64'h2000_0028);
            check("bp_wdata_hold", 64'(bus.icb_cmd_wdata), 64'hCCCC_DDDD);
            tick();
        end
        push_beat(13'd6, 64'h0101_0202_0303_0404, 1'b1);
        cmd_ready_m = 1'b1;
        wait_idle("bp_idle");
        check("bp_cmd_count", 64'(hs_cnt - hs0), 64'(4));

        // Outstanding limit with responses withheld
        rsp_hold = 1'b1;
        hs0 = hs_cnt;
        push_beat(13'd7, 64'h7777_0000_0000_7777, 1'b1);
        push_beat(13'd8, 64'h8888_0000_0000_8888, 1'b1);
        repeat (12) tick();
        check("lim_two_cmds", 64'(hs_cnt - hs0), 64'(2));
        check("lim_valid_low", 64'(bus.icb_cmd_valid), 64'(0));
        rsp_allow = rsp_used + 1;
        repeat (8) tick();
        check("lim_one_more", 64'(hs_cnt - hs0), 64'(3));
        check("lim_valid_low2", 64'(bus.icb_cmd_valid), 64'(0));
        rsp_hold = 1'b0;
        wait_idle("lim_idle");
        check("lim_total", 64'(hs_cnt - hs0), 64'(4));

        // FIFO full: fifth beat dropped, overflow flagged
        do_start(32'h4000_0000);
        cmd_ready_m = 1'b0;
        hs0 = hs_cnt;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                check("full_in_ready", 64'(in_ready), 64'(0));
            end
            push_beat(13'(i + 16), {32'(i + 32'hF0), 32'(i)}, (i < 4));
        end
        check("full_ovf", 64'(ovf), 64'(1));
        cmd_ready_m = 1'b1;
        wait_idle("full_idle");
        check("full_cmd_count", 64'(hs_cnt - hs0), 64'(8));
        check("full_ovf_sticky", 64'(ovf), 64'(1));

        // Response error on the second response; flush while busy
        do_start(32'h0000_1000);
        check("err_ovf_cleared", 64'(ovf), 64'(0));
        err_target = rsp_num + 2;
        d0 = done_cnt;
        push_beat(13'd1, 64'h1234_5678_9ABC_DEF0, 1'b1);
        push_beat(13'd2, 64'h0FED_CBA9_8765_4321, 1'b1);
        pulse_flush();
        wait_idle("err_idle");
        repeat (3) tick();
        check("err_sticky", 64'(err), 64'(1));
        check("err_done_once", 64'(done_cnt - d0), 64'(1));
        do_start(32'h0000_2000);
        check("err_cleared", 64'(err), 64'(0));
        err_target = -1;

        // Address wrap at 2^32
        do_start(32'hFFFF_FFF8);
        push_beat(13'd1, 64'h5555_6666_7777_8888, 1'b1);
        wait_idle("wrap_idle");

        // Asynchronous reset while the high word is pending
        do_start(32'h0000_0100);
        cmd_ready_m = 1'b0;
        push_beat(13'd2, 64'h9999_AAAA_BBBB_CCCC, 1'b1);
        wait_valid("rst_valid");
        cmd_ready_m = 1'b1;
        tick();
        cmd_ready_m = 1'b0;
        check("rst_in_hi_valid", 64'(bus.icb_cmd_valid), 64'(1));
        check("rst_in_hi_addr", 64'(bus.icb_cmd_addr), 64'h0000_0114);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb_q.delete();
        tick();
        bias = rsp_num - hs_cnt;
        tick();
        rst_n = 1'b1;
        tick();

        // Stray response after reset must not underflow or flag an error
        err_target = rsp_num + 1;
        bias = bias + 1;
        repeat (4) tick();
        check("stray_busy", 64'(busy), 64'(0));
        check("stray_err", 64'(err), 64'(0));
        err_target = -1;

        // Normal operation after reset
        cmd_ready_m = 1'b1;
        do_start(32'h3000_0000);
        push_beat(13'h1FFF, 64'hCAFE_F00D_DEAD_BEEF, 1'b1);
        wait_idle("post_rst_idle");
        check("post_rst_queue", 64'(sb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 time units");
        $fatal(1);
    end

endmodule
